fp_multiplier_param: RTL and testbench

- Parametrised IEEE-754 binary floating-point multiplier.
- Exponent and mantissa widths are configurable: single precision by default, half, double or custom.
- Rounding mode is selected at run time: RNE, RTZ, RUP, RDN.
- Reports IEEE exception flags alongside each result; sits in the softmax datapath wherever the fixed single-precision multiplier is used.
- Keeps the codebase's stb/ack streaming handshake: one operation in flight, a and b accepted sequentially.

---
 rtl/fp_multiplier_param.sv | 331 +++++++++++++++++++++++++++++++++
 tb/tb_fp_multiplier_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fp_multiplier_param.sv
// Parametrised IEEE-754 binary multiplier with run-time rounding mode and exception flags.
// Operands arrive one after another over stb/ack; a single operation is in flight at a time.
module fp_multiplier_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [EXP_W+MAN_W:0]     input_a,
    input  logic                     input_a_stb,
    output logic                     input_a_ack,
    input  logic [EXP_W+MAN_W:0]     input_b,
    input  logic                     input_b_stb,
    output logic                     input_b_ack,
    input  logic [1:0]               rnd_mode,
    output logic [EXP_W+MAN_W:0]     output_z,
    output logic [3:0]               output_z_flags,
    output logic                     output_z_stb,
    input  logic                     output_z_ack
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int PW   = 2 * MW + 2;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
    localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic [EXP_W-1:0] BIAS_F     = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_ONES   = '1;
    localparam logic [EXP_W-1:0] EXP_MAX    = EXP_ONES - EXP_W'(1);
    localparam logic [MAN_W-1:0] MAN_ONES   = '1;
    localparam logic [MAN_W-1:0] MAN_ZERO   = '0;
    localparam logic [W-1:0]     QNAN       = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [3:0] GET_A   = 4'd0;
    localparam logic [3:0] GET_B   = 4'd1;
    localparam logic [3:0] UNPACK  = 4'd2;
    localparam logic [3:0] SPECIAL = 4'd3;
    localparam logic [3:0] NORM_A  = 4'd4;
    localparam logic [3:0] NORM_B  = 4'd5;
    localparam logic [3:0] MUL_0   = 4'd6;
    localparam logic [3:0] MUL_1   = 4'd7;
    localparam logic [3:0] NORM_1  = 4'd8;
    localparam logic [3:0] NORM_2  = 4'd9;
    localparam logic [3:0] ROUND   = 4'd10;
    localparam logic [3:0] PACK    = 4'd11;
    localparam logic [3:0] PUT_Z   = 4'd12;

    logic [3:0]           state_q, state_d;
    logic                 a_ack_q, a_ack_d, b_ack_q, b_ack_d, z_stb_q, z_stb_d;
    logic [W-1:0]         out_z_q, out_z_d;
    logic [3:0]           out_flags_q, out_flags_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [1:0]           rnd_q, rnd_d;
    logic [MW-1:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
    logic signed [EW-1:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
    logic                 z_s_q, z_s_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic                 guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;
    logic                 tiny_q, tiny_d, inexact_q, inexact_d;
    logic [W-1:0]         res_q, res_d;
    logic [3:0]           res_flags_q, res_flags_d;

    // Operand classification straight from the stored encodings
    logic a_exp_ones, b_exp_ones, a_exp_zero, b_exp_zero, a_man_nz, b_man_nz;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sign_ab;

    assign a_exp_ones = &a_q[W-2:MAN_W];
    assign b_exp_ones = &b_q[W-2:MAN_W];
    assign a_exp_zero = ~|a_q[W-2:MAN_W];
    assign b_exp_zero = ~|b_q[W-2:MAN_W];
    assign a_man_nz   = |a_q[MAN_W-1:0];
    assign b_man_nz   = |b_q[MAN_W-1:0];
    assign a_nan      = a_exp_ones & a_man_nz;
    assign b_nan      = b_exp_ones & b_man_nz;
    assign a_snan     = a_nan & ~a_q[MAN_W-1];
    assign b_snan     = b_nan & ~b_q[MAN_W-1];
    assign a_inf      = a_exp_ones & ~a_man_nz;
    assign b_inf      = b_exp_ones & ~b_man_nz;
    assign a_zero     = a_exp_zero & ~a_man_nz;
    assign b_zero     = b_exp_zero & ~b_man_nz;
    assign sign_ab    = a_q[W-1] ^ b_q[W-1];

    logic             rnd_inexact, round_up;
    logic [EXP_W-1:0] pack_exp;
    logic [W-1:0]     ovf_inf, ovf_max;

    assign rnd_inexact = guard_q | round_q | sticky_q;
    assign pack_exp    = (z_e_q == EMIN_E && !z_m_q[MW-1]) ? '0 : z_e_q[EXP_W-1:0] + BIAS_F;
    assign ovf_inf     = {z_s_q, EXP_ONES, MAN_ZERO};
    assign ovf_max     = {z_s_q, EXP_MAX, MAN_ONES};

    always_comb begin
        round_up = 1'b0;
        case (rnd_q)
            2'd0:    round_up = guard_q & (round_q | sticky_q | z_m_q[0]);
            2'd1:    round_up = 1'b0;
            2'd2:    round_up = rnd_inexact & ~z_s_q;
            default: round_up = rnd_inexact & z_s_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_ack_d     = a_ack_q;
        b_ack_d     = b_ack_q;
        z_stb_d     = z_stb_q;
        out_z_d     = out_z_q;
        out_flags_d = out_flags_q;
        a_d         = a_q;
        b_d         = b_q;
        rnd_d       = rnd_q;
        a_m_d       = a_m_q;
        b_m_d       = b_m_q;
        z_m_d       = z_m_q;
        a_e_d       = a_e_q;
        b_e_d       = b_e_q;
        z_e_d       = z_e_q;
        z_s_d       = z_s_q;
        prod_d      = prod_q;
        guard_d     = guard_q;
        round_d     = round_q;
        sticky_d    = sticky_q;
        tiny_d      = tiny_q;
        inexact_d   = inexact_q;
        res_d       = res_q;
        res_flags_d = res_flags_q;
        case (state_q)
            GET_A: begin
                a_ack_d = 1'b1;
                if (a_ack_q && input_a_stb) begin
                    a_d     = input_a;
                    a_ack_d = 1'b0;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                b_ack_d = 1'b1;
                if (b_ack_q && input_b_stb) begin
                    b_d     = input_b;
                    rnd_d   = rnd_mode;
                    b_ack_d = 1'b0;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                a_m_d   = {1'b0, a_q[MAN_W-1:0]};
                b_m_d   = {1'b0, b_q[MAN_W-1:0]};
                a_e_d   = $signed({2'b00, a_q[W-2:MAN_W]}) - BIAS_E;
                b_e_d   = $signed({2'b00, b_q[W-2:MAN_W]}) - BIAS_E;
                state_d = SPECIAL;
            end
            SPECIAL: begin
                state_d     = PUT_Z;
                res_flags_d = 4'b0000;
                if (a_nan || b_nan) begin
                    res_d          = QNAN;
                    res_flags_d[3] = a_snan | b_snan;
                end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
                    res_d          = QNAN;
                    res_flags_d[3] = 1'b1;
                end else if (a_inf || b_inf) begin
                    res_d = {sign_ab, EXP_ONES, MAN_ZERO};
                end else if (a_zero || b_zero) begin
                    res_d = {sign_ab, {(W-1){1'b0}}};
                end else begin
                    // Denormals keep the minimum exponent and no hidden bit
                    state_d = NORM_A;
                    if (a_exp_zero) a_e_d = EMIN_E;
                    else            a_m_d[MW-1] = 1'b1;
                    if (b_exp_zero) b_e_d = EMIN_E;
                    else            b_m_d[MW-1] = 1'b1;
                end
            end
            NORM_A: begin
                if (a_m_q[MW-1]) begin
                    state_d = NORM_B;
                end else begin
                    a_m_d = a_m_q << 1;
                    a_e_d = a_e_q - ONE_E;
                end
            end
            NORM_B: begin
                if (b_m_q[MW-1]) begin
                    state_d = MUL_0;
                end else begin
                    b_m_d = b_m_q << 1;
                    b_e_d = b_e_q - ONE_E;
                end
            end
            MUL_0: begin
                z_s_d   = sign_ab;
                z_e_d   = a_e_q + b_e_q + ONE_E;
                prod_d  = (PW'(a_m_q) * PW'(b_m_q)) << 2;
                tiny_d  = 1'b0;
                state_d = MUL_1;
            end
            MUL_1: begin
                z_m_d    = prod_q[PW-1 -: MW];
                guard_d  = prod_q[PW-MW-1];
                round_d  = prod_q[PW-MW-2];
                sticky_d = |prod_q[PW-MW-3:0];
                state_d  = NORM_1;
            end
            NORM_1: begin
                if (!z_m_q[MW-1]) begin
                    z_e_d   = z_e_q - ONE_E;
                    z_m_d   = {z_m_q[MW-2:0], guard_q};
                    guard_d = round_q;
                    round_d = 1'b0;
                end else begin
                    state_d = NORM_2;
                end
            end
            NORM_2: begin
                if (z_e_q < EMIN_E) begin
                    z_e_d    = z_e_q + ONE_E;
                    z_m_d    = z_m_q >> 1;
                    guard_d  = z_m_q[0];
                    round_d  = guard_q;
                    sticky_d = sticky_q | round_q;
                    tiny_d   = 1'b1;
                end else begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                inexact_d = rnd_inexact;
                if (round_up) begin
                    if (&z_m_q) begin
                        z_m_d = {1'b1, {(MW-1){1'b0}}};
                        z_e_d = z_e_q + ONE_E;
                    end else begin
                        z_m_d = z_m_q + MW'(1);
                    end
                end
                state_d = PACK;
            end
            PACK: begin
                res_flags_d = {2'b00, tiny_q & inexact_q, inexact_q};
                if (z_e_q > BIAS_E) begin
                    res_flags_d[2] = 1'b1;
                    res_flags_d[0] = 1'b1;
                    case (rnd_q)
                        2'd0:    res_d = ovf_inf;
                        2'd1:    res_d = ovf_max;
                        2'd2:    res_d = z_s_q ? ovf_max : ovf_inf;
                        default: res_d = z_s_q ? ovf_inf : ovf_max;
                    endcase
                end else begin
                    res_d = {z_s_q, pack_exp, z_m_q[MAN_W-1:0]};
                end
                state_d = PUT_Z;
            end
            PUT_Z: begin
                if (!z_stb_q) begin
                    out_z_d     = res_q;
                    out_flags_d = res_flags_q;
                    z_stb_d     = 1'b1;
                end else if (output_z_ack) begin
                    z_stb_d = 1'b0;
                    state_d = GET_A;
                end
            end
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= GET_A;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            z_stb_q     <= 1'b0;
            out_z_q     <= '0;
            out_flags_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rnd_q       <= '0;
            a_m_q       <= '0;
            b_m_q       <= '0;
            z_m_q       <= '0;
            a_e_q       <= '0;
            b_e_q       <= '0;
            z_e_q       <= '0;
            z_s_q       <= 1'b0;
            prod_q      <= '0;
            guard_q     <= 1'b0;
            round_q     <= 1'b0;
            sticky_q    <= 1'b0;
            tiny_q      <= 1'b0;
            inexact_q   <= 1'b0;
            res_q       <= '0;
            res_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            z_stb_q     <= z_stb_d;
            out_z_q     <= out_z_d;
            out_flags_q <= out_flags_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rnd_q       <= rnd_d;
            a_m_q       <= a_m_d;
            b_m_q       <= b_m_d;
            z_m_q       <= z_m_d;
            a_e_q       <= a_e_d;
            b_e_q       <= b_e_d;
            z_e_q       <= z_e_d;
            z_s_q       <= z_s_d;
            prod_q      <= prod_d;
            guard_q     <= guard_d;
            round_q     <= round_d;
            sticky_q    <= sticky_d;
            tiny_q      <= tiny_d;
            inexact_q   <= inexact_d;
            res_q       <= res_d;
            res_flags_q <= res_flags_d;
        end
    end

    assign input_a_ack    = a_ack_q;
    assign input_b_ack    = b_ack_q;
    assign output_z       = out_z_q;
    assign output_z_flags = out_flags_q;
    assign output_z_stb   = z_stb_q;

endmodule

// File: tb/tb_fp_multiplier_param.sv
// Directed bench for fp_multiplier_param: single-precision instance plus a half-precision instance.
module tb_fp_multiplier_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a, in_b, out_z;
    logic        a_stb, a_ack, b_stb, b_ack, z_stb, z_ack;
    logic [1:0]  rm;
    logic [3:0]  z_flags;

    logic [15:0] h_a, h_b, h_z;
    logic        h_a_stb, h_a_ack, h_b_stb, h_b_ack, h_z_stb, h_z_ack;
    logic [3:0]  h_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fp_multiplier_param dut (
        .clk(clk), .rst(rst),
        .input_a(in_a), .input_a_stb(a_stb), .input_a_ack(a_ack),
        .input_b(in_b), .input_b_stb(b_stb), .input_b_ack(b_ack),
        .rnd_mode(rm),
        .output_z(out_z), .output_z_flags(z_flags),
        .output_z_stb(z_stb), .output_z_ack(z_ack)
    );

    fp_multiplier_param #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst),
        .input_a(h_a), .input_a_stb(h_a_stb), .input_a_ack(h_a_ack),
        .input_b(h_b), .input_b_stb(h_b_stb), .input_b_ack(h_b_ack),
        .rnd_mode(rm),
        .output_z(h_z), .output_z_flags(h_flags),
        .output_z_stb(h_z_stb), .output_z_ack(h_z_ack)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Returns at the negedge just after the b-transfer edge
    task automatic send_ab(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] mode);
        int cyc;
        @(negedge clk);
        in_a  = a;
        a_stb = 1'b1;
        cyc = 0;
        while (!a_ack && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/a_ack"}, a_ack, 1);
        @(negedge clk);
        a_stb = 1'b0;
        in_b  = b;
        b_stb = 1'b1;
        rm    = mode;
        cyc = 0;
        while (!b_ack && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "/b_ack"}, b_ack, 1);
        @(negedge clk);
        b_stb = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] mode, input logic [31:0] exp_z,
                          input logic [3:0] exp_f, input int exp_lat, input int hold);
        int lat;
        send_ab(tag, a, b, mode);
        lat = 0;
        while (!z_stb && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/stb"}, z_stb, 1);
        check({tag, "/z"}, out_z, exp_z);
        check({tag, "/flags"}, z_flags, exp_f);
        if (exp_lat >= 0) check({tag, "/latency"}, lat, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "/hold_z"}, out_z, exp_z);
            check({tag, "/hold_stb"}, z_stb, 1);
            check({tag, "/hold_a_ack"}, a_ack, 0);
        end
        z_ack = 1'b1;
        @(negedge clk);
        z_ack = 1'b0;
        check({tag, "/stb_drop"}, z_stb, 0);
        check({tag, "/a_ack_low"}, a_ack, 0);
        @(negedge clk);
        check({tag, "/a_ack_rerise"}, a_ack, 1);
        $display("[TB] %s a=%h b=%h rm=%0d -> z=%h flags=%b latency=%0d",
                 tag, a, b, mode, out_z, z_flags, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        in_a = '0; in_b = '0; a_stb = 1'b0; b_stb = 1'b0; z_ack = 1'b0; rm = 2'd0;
        h_a = '0; h_b = '0; h_a_stb = 1'b0; h_b_stb = 1'b0; h_z_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/z", out_z, 0);
        check("reset/flags", z_flags, 0);
        check("reset/stb", z_stb, 0);
        check("reset/a_ack", a_ack, 0);
        check("reset/b_ack", b_ack, 0);
        check("reset/h_z", h_z, 0);
        rst = 1'b0;

        run_op("2x3",         32'h40000000, 32'h40400000, 2'd0, 32'h40C00000, 4'b0000, 12, 5);
        run_op("1.5x1.5",     32'h3FC00000, 32'h3FC00000, 2'd0, 32'h40100000, 4'b0000, 11, 0);
        run_op("inf_x_0",     32'h7F800000, 32'h00000000, 2'd0, 32'h7FC00000, 4'b1000, 3, 0);
        run_op("snan_x_1",    32'h7F800001, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b1000, 3, 0);
        run_op("qnan_x_1",    32'h7FC00000, 32'h3F800000, 2'd0, 32'h7FC00000, 4'b0000, 3, 0);
        run_op("ninf_x_2",    32'hFF800000, 32'h40000000, 2'd0, 32'hFF800000, 4'b0000, 3, 0);
        run_op("nzero_x_1",   32'h80000000, 32'h3F800000, 2'd0, 32'h80000000, 4'b0000, 3, 0);
        run_op("ovf_rne",     32'h7F7FFFFF, 32'h40000000, 2'd0, 32'h7F800000, 4'b0101, 12, 0);
        run_op("ovf_rtz",     32'h7F7FFFFF, 32'h40000000, 2'd1, 32'h7F7FFFFF, 4'b0101, 12, 0);
        run_op("novf_rup",    32'hFF7FFFFF, 32'h40000000, 2'd2, 32'hFF7FFFFF, 4'b0101, -1, 0);
        run_op("novf_rdn",    32'hFF7FFFFF, 32'h40000000, 2'd3, 32'hFF800000, 4'b0101, -1, 0);
        run_op("ulp_rne",     32'h3F800001, 32'h3F800001, 2'd0, 32'h3F800002, 4'b0001, 12, 0);
        run_op("ulp_rup",     32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 4'b0001, -1, 0);
        run_op("ulp_rdn",     32'h3F800001, 32'h3F800001, 2'd3, 32'h3F800002, 4'b0001, -1, 0);
        run_op("tiny_exact",  32'h00800000, 32'h3F000000, 2'd0, 32'h00400000, 4'b0000, -1, 0);
        run_op("min_half_rne",32'h00000001, 32'h3F000000, 2'd0, 32'h00000000, 4'b0011, -1, 0);
        run_op("min_half_rup",32'h00000001, 32'h3F000000, 2'd2, 32'h00000001, 4'b0011, -1, 0);
        run_op("denorm_x_1",  32'h00000003, 32'h3F800000, 2'd0, 32'h00000003, 4'b0000, -1, 0);
        run_op("denorm_tie",  32'h00000003, 32'h3F000000, 2'd0, 32'h00000002, 4'b0011, -1, 0);

        // Abort an operation while it sits in NORM_1, then run a fresh one
        send_ab("rst_mid", 32'h40000000, 32'h40400000, 2'd0);
        repeat (6) @(negedge clk);
        check("rst_mid/pre_state", dut.state_q, 8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid/state", dut.state_q, 0);
        check("rst_mid/z", out_z, 0);
        check("rst_mid/flags", z_flags, 0);
        check("rst_mid/stb", z_stb, 0);
        check("rst_mid/a_ack", a_ack, 0);
        check("rst_mid/b_ack", b_ack, 0);
        run_op("after_rst",   32'h40400000, 32'h40400000, 2'd0, 32'h41100000, 4'b0000, 11, 0);

        // Half precision: 2 x 3
        @(negedge clk);
        h_a = 16'h4000;
        h_a_stb = 1'b1;
        cyc = 0;
        while (!h_a_ack && cyc < 100) begin @(negedge clk); cyc++; end
        check("half/a_ack", h_a_ack, 1);
        @(negedge clk);
        h_a_stb = 1'b0;
        h_b = 16'h4200;
        h_b_stb = 1'b1;
        rm = 2'd0;
        cyc = 0;
        while (!h_b_ack && cyc < 100) begin @(negedge clk); cyc++; end
        check("half/b_ack", h_b_ack, 1);
        @(negedge clk);
        h_b_stb = 1'b0;
        cyc = 0;
        while (!h_z_stb && cyc < 400) begin @(negedge clk); cyc++; end
        check("half/stb", h_z_stb, 1);
        check("half/z", h_z, 16'h4600);
        check("half/flags", h_flags, 4'b0000);
        check("half/latency", cyc, 12);
        h_z_ack = 1'b1;
        @(negedge clk);
        h_z_ack = 1'b0;
        check("half/stb_drop", h_z_stb, 0);
        $display("[TB] half a=4000 b=4200 -> z=%h flags=%b latency=%0d", h_z, h_flags, cyc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
